arinc_rx_word: RTL and testbench

Word assembler for the ARINC-429 receive path. It takes the qualified bipolar bit pulses RXP/RXN produced by the receive timer/threshold stage, frames 32-bit words using the inter-word null gap, and checks odd parity. It presents each complete word with a one-cycle ready strobe to the host-side buffer. It sits directly downstream of the RXP/RXN generators in the receiver chain.

---
 rtl/arinc_rx_pkg.sv | 29 ++
 rtl/arinc_gap_timer.sv | 56 +++++
 rtl/arinc_rx_word.sv | 153 +++++++++++++++
 tb/tb_arinc_rx_word.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arinc_rx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arinc_rx_pkg : shared types and constants for the ARINC-429 RX  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package arinc_rx_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_BOTH  = 2'd2;
  localparam logic [1:0] ERR_FAST  = 2'd3;

  localparam int ARINC_WORD_LEN = 32;

  // The label is transmitted MSB first, so the first-received byte is mirrored.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arinc_gap_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arinc_gap_timer : idle-gap and bit-spacing saturating counters  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module arinc_gap_timer #(
  parameter int GAP_CYC     = 1000,
  parameter int MIN_BIT_CYC = 200
) (
  input  logic clk,
  input  logic res,
  input  logic line_act_i,
  input  logic bit_edge_i,
  output logic gap_o,
  output logic early_o
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int SW = $clog2(MIN_BIT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC);
  localparam logic [SW-1:0] SPC_MAX = SW'(MIN_BIT_CYC);

  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (line_act_i) begin
      gcnt_d = '0;
    end else if (gcnt_q != GAP_MAX) begin
      gcnt_d = gcnt_q + 1'b1;
    end

    scnt_d = scnt_q;
    if (bit_edge_i) begin
      scnt_d = '0;
    end else if (scnt_q != SPC_MAX) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      gcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign gap_o   = (gcnt_q == GAP_MAX);
  assign early_o = (scnt_q < SPC_MAX);

endmodule
`default_nettype wire

// File: rtl/arinc_rx_word.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arinc_rx_word : frames RXP/RXN bit pulses into 32-bit words     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module arinc_rx_word
  import arinc_rx_pkg::*;
#(
  parameter int GAP_CYC     = 1000,
  parameter int MIN_BIT_CYC = 200
) (
  input  logic        clk,
  input  logic        res,
  input  logic        RXP,
  input  logic        RXN,
  output logic [31:0] word,
  output logic [7:0]  label,
  output logic        rdy,
  output logic        par_err,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [5:0]  N_bit
);

  localparam logic [5:0] LAST_BIT = 6'(ARINC_WORD_LEN - 1);

  logic        rxp_q, rxn_q;
  logic        one_edge, zero_edge, bit_edge, both, both_new;
  logic        gap, early;
  state_e      state_q, state_d;
  logic [5:0]  nbit_q, nbit_d;
  logic [31:0] shreg_q, shreg_d, full_w;
  logic [31:0] word_q, word_d;
  logic [7:0]  label_q, label_d;
  logic        par_q, par_d, rdy_q, rdy_d, err_q, err_d;
  logic [1:0]  code_q, code_d;

  assign one_edge  = RXP & ~rxp_q;
  assign zero_edge = RXN & ~rxn_q;
  assign bit_edge  = one_edge | zero_edge;
  assign both      = RXP & RXN;
  // Strobe the both-high error once per occurrence, not every cycle it persists.
  assign both_new  = both & ~(rxp_q & rxn_q);

  arinc_gap_timer #(
    .GAP_CYC    (GAP_CYC),
    .MIN_BIT_CYC(MIN_BIT_CYC)
  ) u_gap_timer (
    .clk       (clk),
    .res       (res),
    .line_act_i(RXP | RXN),
    .bit_edge_i(bit_edge),
    .gap_o     (gap),
    .early_o   (early)
  );

  always_comb begin
    full_w = shreg_q;
    full_w[nbit_q[4:0]] = one_edge;

    state_d = state_q;
    nbit_d  = nbit_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    label_d = label_q;
    par_d   = par_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    if (both) begin
      err_d   = both_new;
      code_d  = both_new ? ERR_BOTH : code_q;
      nbit_d  = '0;
      shreg_d = '0;
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (gap) begin
            state_d = RECV;
          end
        end
        RECV: begin
          // A gap ends any partial word before a coincident edge can extend it.
          if (gap && nbit_q != '0) begin
            err_d   = 1'b1;
            code_d  = ERR_SHORT;
            nbit_d  = '0;
            shreg_d = '0;
          end else if (bit_edge) begin
            if (nbit_q != '0 && early) begin
              err_d   = 1'b1;
              code_d  = ERR_FAST;
              nbit_d  = '0;
              shreg_d = '0;
              state_d = HUNT;
            end else if (nbit_q == LAST_BIT) begin
              word_d  = full_w;
              label_d = rev8(full_w[7:0]);
              par_d   = ~^full_w;
              rdy_d   = 1'b1;
              nbit_d  = '0;
              shreg_d = '0;
            end else begin
              shreg_d = full_w;
              nbit_d  = nbit_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      rxp_q   <= 1'b0;
      rxn_q   <= 1'b0;
      state_q <= HUNT;
      nbit_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      label_q <= '0;
      par_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      rxp_q   <= RXP;
      rxn_q   <= RXN;
      state_q <= state_d;
      nbit_q  <= nbit_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      label_q <= label_d;
      par_q   <= par_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign word     = word_q;
  assign label    = label_q;
  assign rdy      = rdy_q;
  assign par_err  = par_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign N_bit    = nbit_q;

endmodule
`default_nettype wire

// File: tb/tb_arinc_rx_word.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_arinc_rx_word : directed bench for arinc_rx_word             |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_arinc_rx_word;

  // Timing scaled down 10x: gap 100 cycles, min spacing 20, bit period 50.
  localparam int GAP  = 100;
  localparam int MINB = 20;
  localparam int HALF = 25;
  localparam int IDLE = 120;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        RXP = 1'b0;
  logic        RXN = 1'b0;
  logic [31:0] word;
  logic [7:0]  label;
  logic        rdy, par_err, err;
  logic [1:0]  err_code;
  logic [5:0]  N_bit;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;

  arinc_rx_word #(
    .GAP_CYC    (GAP),
    .MIN_BIT_CYC(MINB)
  ) dut (
    .clk     (clk),
    .res     (res),
    .RXP     (RXP),
    .RXN     (RXN),
    .word    (word),
    .label   (label),
    .rdy     (rdy),
    .par_err (par_err),
    .err     (err),
    .err_code(err_code),
    .N_bit   (N_bit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy) rdy_cnt <= rdy_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    RXP = b;
    RXN = ~b;
    idle(HALF);
    RXP = 1'b0;
    RXN = 1'b0;
    idle(HALF);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic check_word(input string tag, input int n_rdy, input logic [31:0] w,
                            input logic [7:0] lbl, input logic pe);
    check({tag, ".rdy_cnt"}, 32'(rdy_cnt), 32'(n_rdy));
    check({tag, ".word"}, word, w);
    check({tag, ".label"}, {24'd0, label}, {24'd0, lbl});
    check({tag, ".par_err"}, {31'd0, par_err}, {31'd0, pe});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".word"}, word, 32'd0);
    check({tag, ".label"}, {24'd0, label}, 32'd0);
    check({tag, ".rdy"}, {31'd0, rdy}, 32'd0);
    check({tag, ".par_err"}, {31'd0, par_err}, 32'd0);
    check({tag, ".err"}, {31'd0, err}, 32'd0);
    check({tag, ".err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, ".N_bit"}, {26'd0, N_bit}, 32'd0);
  endtask

  initial begin
    idle(3);
    check_zero("reset");
    res = 1'b0;
    idle(IDLE);

    // Two set bits: even parity flagged, label is bit-reversed low byte.
    send_word(32'h8000_0001, 32);
    check_word("w8000_0001", 1, 32'h8000_0001, 8'h80, 1'b1);
    check("w8000_0001.err_cnt", 32'(err_cnt), 32'd0);

    idle(IDLE);
    send_word(32'h0000_0003, 32);
    check_word("w0000_0003", 2, 32'h0000_0003, 8'hC0, 1'b1);
    check("w0000_0003.err_cnt", 32'(err_cnt), 32'd0);

    // Five ones: odd parity accepted.
    idle(IDLE);
    send_word(32'h0000_00A7, 32);
    check_word("w0000_00A7", 3, 32'h0000_00A7, 8'hE5, 1'b0);

    // Short word terminated by a gap.
    idle(IDLE);
    send_word(32'h0000_0155, 10);
    check("short.N_bit_mid", {26'd0, N_bit}, 32'd10);
    idle(IDLE);
    check("short.err_cnt", 32'(err_cnt), 32'd1);
    check("short.err_code", {30'd0, err_code}, 32'd1);
    check("short.N_bit", {26'd0, N_bit}, 32'd0);
    check("short.rdy_cnt", 32'(rdy_cnt), 32'd3);
    send_word(32'h1234_5678, 32);
    check_word("after_short", 4, 32'h1234_5678, 8'h1E, 1'b0);

    // Both lines high mid-word.
    idle(IDLE);
    send_word(32'h0000_0015, 5);
    RXP = 1'b1;
    RXN = 1'b1;
    idle(1);
    check("both.err", {31'd0, err}, 32'd1);
    check("both.err_code", {30'd0, err_code}, 32'd2);
    check("both.N_bit", {26'd0, N_bit}, 32'd0);
    idle(4);
    RXP = 1'b0;
    RXN = 1'b0;
    idle(HALF);
    check("both.err_cnt", 32'(err_cnt), 32'd2);
    send_word(32'hFFFF_0000, 32);
    check("both.ignored_rdy", 32'(rdy_cnt), 32'd4);
    check("both.ignored_N_bit", {26'd0, N_bit}, 32'd0);
    idle(IDLE);
    send_word(32'h0F0F_0F0F, 32);
    check_word("after_both", 5, 32'h0F0F_0F0F, 8'hF0, 1'b1);

    // Second edge only 10 cycles after the first.
    RXP = 1'b1;
    idle(5);
    RXP = 1'b0;
    idle(5);
    RXN = 1'b1;
    idle(1);
    check("fast.err", {31'd0, err}, 32'd1);
    check("fast.err_code", {30'd0, err_code}, 32'd3);
    check("fast.N_bit", {26'd0, N_bit}, 32'd0);
    idle(4);
    RXN = 1'b0;
    idle(HALF);
    send_word(32'h0000_0005, 3);
    check("fast.hunt_N_bit", {26'd0, N_bit}, 32'd0);
    check("fast.err_cnt", 32'(err_cnt), 32'd3);
    idle(IDLE);
    send_word(32'h0000_0001, 32);
    check_word("after_fast", 6, 32'h0000_0001, 8'h80, 1'b0);

    // Reset mid-word.
    idle(IDLE);
    send_word(32'hFFFF_FFFF, 20);
    check("res.N_bit_mid", {26'd0, N_bit}, 32'd20);
    res = 1'b1;
    idle(1);
    res = 1'b0;
    check_zero("res_mid");
    send_word(32'hFFFF_FFFF, 32);
    check("res.no_gap_rdy", 32'(rdy_cnt), 32'd6);
    idle(IDLE);
    send_word(32'hC3A5_0035, 32);
    check_word("after_res", 7, 32'hC3A5_0035, 8'hAC, 1'b1);
    check("final.err_cnt", 32'(err_cnt), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
